// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the ROM read port and the arbiter.
// The arbiter takes the slave view; the core/ROM side takes the master view.
interface imem_port_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_rerr;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_rerr;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_rerr,
    output d_gnt, d_rvalid, d_rdata, d_rerr, mem_addr
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_rerr,
    input  d_gnt, d_rvalid, d_rdata, d_rerr, mem_addr
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the combinational instruction-ROM read port between fetch (F) and data (D) requesters,
// D-priority with starvation protection for F, one registered response word per grant.
module imem_port_arbiter #(
  parameter int IROM_SPACE   = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  imem_port_arbiter_if.slave bus
);

  localparam logic [31:0] MAX_ADDR = 32'(IROM_SPACE - 4);
  localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        f_gnt_p0;
  logic        d_gnt_p0;
  logic        err_p0;
  logic [31:0] word_p0;

  logic        f_vld_p1;
  logic        d_vld_p1;
  logic [31:0] f_rdata_p1;
  logic [31:0] d_rdata_p1;
  logic        f_rerr_p1;
  logic        d_rerr_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > MAX_ADDR);
  endfunction

  // Stage p0: combinational grant, ROM address mux and error check on the granted address
  always_comb begin
    f_gnt_p0 = 1'b0;
    d_gnt_p0 = 1'b0;
    if (!rst) begin
      if (bus.f_req && (!bus.d_req || starve_cnt == LIMIT)) begin
        f_gnt_p0 = 1'b1;
      end else if (bus.d_req) begin
        d_gnt_p0 = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_addr = 32'h0;
    if (f_gnt_p0) begin
      bus.mem_addr = bus.f_addr;
    end else if (d_gnt_p0) begin
      bus.mem_addr = bus.d_addr;
    end
  end

  assign err_p0  = addr_err(bus.mem_addr);
  assign word_p0 = err_p0 ? 32'h0 : bus.mem_rdata;

  assign bus.f_gnt = f_gnt_p0;
  assign bus.d_gnt = d_gnt_p0;

  // Stage p1: registered responses; rdata is reset too so both ports come up reading zero
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      f_vld_p1   <= 1'b0;
      d_vld_p1   <= 1'b0;
      f_rerr_p1  <= 1'b0;
      d_rerr_p1  <= 1'b0;
      f_rdata_p1 <= 32'h0;
      d_rdata_p1 <= 32'h0;
    end else begin
      f_vld_p1 <= f_gnt_p0;
      d_vld_p1 <= d_gnt_p0;
      if (f_gnt_p0) begin
        f_rdata_p1 <= word_p0;
        f_rerr_p1  <= err_p0;
      end
      if (d_gnt_p0) begin
        d_rdata_p1 <= word_p0;
        d_rerr_p1  <= err_p0;
      end
      if (!bus.f_req || f_gnt_p0) begin
        starve_cnt <= 4'd0;
      end else if (d_gnt_p0) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

  // A response due in a cycle where rst is raised is dropped immediately, not one cycle late
  assign bus.f_rvalid = f_vld_p1 & ~rst;
  assign bus.d_rvalid = d_vld_p1 & ~rst;
  assign bus.f_rerr   = f_rerr_p1 & ~rst;
  assign bus.d_rerr   = d_rerr_p1 & ~rst;
  assign bus.f_rdata  = rst ? 32'h0 : f_rdata_p1;
  assign bus.d_rdata  = rst ? 32'h0 : d_rdata_p1;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: reset, single grants, contention/starvation,
// address errors, streaming fetch and reset in the middle of a transfer.
module tb_imem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_port_arbiter_if bus();

  imem_port_arbiter #(.IROM_SPACE(1024), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] rom [0:1023];
  logic [9:0] ra;
  assign ra = bus.mem_addr[9:0];
  assign bus.mem_rdata = (bus.mem_addr <= 32'd1020) ?
    {rom[ra + 10'd3], rom[ra + 10'd2], rom[ra + 10'd1], rom[ra]} : 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {rom[a + 3], rom[a + 2], rom[a + 1], rom[a]};
  endfunction

  // One clock: inputs change just after the rising edge, then everything is sampled mid-cycle.
  task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic [31:0] da);
    @(posedge clk);
    #1;
    rst        = r;
    bus.f_req  = fr;
    bus.f_addr = fa;
    bus.d_req  = dr;
    bus.d_addr = da;
    #1;
  endtask

  logic [5:0] exp_f;

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 37 + 11);
    rom[8]  = 8'h13;
    rom[9]  = 8'h05;
    rom[10] = 8'h10;
    rom[11] = 8'h00;

    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_addr = 32'h0;

    // Reset: no grants even with both requesting, outputs quiet
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h4);
    chk("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rst_f_rdata", bus.f_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);

    // Single fetch from 0x8
    step(1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
    chk("t1_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("t1_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("t1_mem_addr", bus.mem_addr, 32'h8);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("t1_f_rdata", bus.f_rdata, 32'h00100513);
    chk("t1_f_rerr", 32'(bus.f_rerr), 32'd0);
    chk("t1_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("idle_mem_addr", bus.mem_addr, 32'h0);

    // Contention: D,D,D,D,F,D
    exp_f = 6'b010000;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'h10, 1'b1, 32'h20);
      chk($sformatf("t2_f_gnt%0d", i), 32'(bus.f_gnt), 32'(exp_f[i]));
      chk($sformatf("t2_d_gnt%0d", i), 32'(bus.d_gnt), 32'(!exp_f[i]));
      if (i > 0) begin
        chk($sformatf("t2_f_rvalid%0d", i), 32'(bus.f_rvalid), 32'(exp_f[i-1]));
        chk($sformatf("t2_d_rvalid%0d", i), 32'(bus.d_rvalid), 32'(!exp_f[i-1]));
      end
      if (i == 5) chk("t2_f_rdata", bus.f_rdata, word_at(32'h10));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t2_f_rvalid_end", 32'(bus.f_rvalid), 32'd0);
    chk("t2_d_rvalid_end", 32'(bus.d_rvalid), 32'd1);
    chk("t2_d_rdata", bus.d_rdata, word_at(32'h20));

    // Misaligned data read
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h6);
    chk("t3_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("t3_mem_addr", bus.mem_addr, 32'h6);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("t3_d_rerr", 32'(bus.d_rerr), 32'd1);
    chk("t3_d_rdata", bus.d_rdata, 32'h0);

    // Range boundaries, back to back
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'd1020);
    chk("t4_d_gnt", 32'(bus.d_gnt), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'd1024);
    chk("t4_last_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("t4_last_rerr", 32'(bus.d_rerr), 32'd0);
    chk("t4_last_rdata", bus.d_rdata, word_at(1020));
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    chk("t4_end_rerr", 32'(bus.d_rerr), 32'd1);
    chk("t4_end_rdata", bus.d_rdata, 32'h0);
    chk("t4_top_mem_addr", bus.mem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t4_top_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("t4_top_rerr", 32'(bus.d_rerr), 32'd1);

    // Streaming fetch 0,4,8,12
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i < 4), 32'(4 * i), 1'b0, 32'h0);
      if (i < 4) chk($sformatf("t5_f_gnt%0d", i), 32'(bus.f_gnt), 32'd1);
      if (i > 0) begin
        chk($sformatf("t5_f_rvalid%0d", i), 32'(bus.f_rvalid), 32'd1);
        chk($sformatf("t5_f_rdata%0d", i), bus.f_rdata, word_at(4 * (i - 1)));
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t5_f_rvalid_end", 32'(bus.f_rvalid), 32'd0);
    chk("t5_f_rdata_hold", bus.f_rdata, word_at(12));

    // Build starvation to the limit, then reset mid-transfer
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h40, 1'b1, 32'h44);
      chk($sformatf("t6_d_gnt%0d", i), 32'(bus.d_gnt), 32'd1);
    end
    step(1'b1, 1'b1, 32'h40, 1'b1, 32'h44);
    chk("t6_rst_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("t6_rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("t6_rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("t6_rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    chk("t6_rst_d_rdata", bus.d_rdata, 32'h0);
    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h44);
    chk("t6_post_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("t6_post_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("t6_post_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6_resp_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("t6_resp_d_rdata", bus.d_rdata, word_at(32'h44));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
